// File: rtl/conv_mem_responder_if.sv
// Conv-engine side of the memory responder: read request/response and output write channel.
interface conv_mem_responder_if #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 32
);
  logic              ready;
  logic              read_en;
  logic [ADDR_W-1:0] bram_rd_addr;
  logic [DATA_W-1:0] input_pixels;
  logic [DATA_W-1:0] weights;
  logic              valid;
  logic              write_en;
  logic [ADDR_W-1:0] bram_wr_addr;
  logic [DATA_W-1:0] output_pixels;
  logic              tile_done;

  modport master (
    output read_en, bram_rd_addr, write_en, bram_wr_addr, output_pixels, tile_done,
    input  ready, input_pixels, weights, valid
  );

  modport slave (
    input  read_en, bram_rd_addr, write_en, bram_wr_addr, output_pixels, tile_done,
    output ready, input_pixels, weights, valid
  );
endinterface

// File: rtl/conv_mem_responder.sv
// Pixel/weight/output BRAM model serving a convolution engine: host preload and readback,
// pipelined fixed-latency reads and counted output writes under an IDLE/RUN/DRAIN controller.
module conv_mem_responder #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 2,
  localparam int IDX_W = $clog2(DEPTH),
  localparam int CNT_W = IDX_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              host_we,
  input  logic              host_sel,
  input  logic [IDX_W-1:0]  host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic [IDX_W-1:0]  host_raddr,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  wr_count,
  output logic              addr_err,
  output logic [1:0]        dbg_state,
  conv_mem_responder_if.slave eng
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   ready_q, ready_d;
  logic   done_q, done_d;
  logic   addr_err_q, addr_err_d;
  logic [CNT_W-1:0]  wr_count_q, wr_count_d;
  logic [DATA_W-1:0] host_rdata_q, host_rdata_d;

  logic [DATA_W-1:0] pix_mem [DEPTH];
  logic [DATA_W-1:0] wt_mem  [DEPTH];
  logic [DATA_W-1:0] out_mem [DEPTH];

  // Read pipeline: stage 0 captures memory data, the last stage drives the engine.
  // A stage's data only moves when a valid entry moves into it, so the outputs hold while idle.
  logic [RD_LAT-1:0] pipe_vld_q, pipe_vld_d;
  logic [DATA_W-1:0] pipe_pix_q [RD_LAT];
  logic [DATA_W-1:0] pipe_pix_d [RD_LAT];
  logic [DATA_W-1:0] pipe_wt_q  [RD_LAT];
  logic [DATA_W-1:0] pipe_wt_d  [RD_LAT];

  logic             rd_acc, rd_oob, wr_act, wr_oob, wr_ok, pending;
  logic [IDX_W-1:0] rd_idx, wr_idx;

  // Handshake: ready is high for the whole RUN window; a read is taken on every edge where
  // ready and read_en are both high, and valid marks each cycle that carries a completed read.
  assign rd_acc  = (state_q == S_RUN) && eng.read_en;
  assign rd_oob  = eng.bram_rd_addr >= ADDR_W'(DEPTH);
  assign rd_idx  = eng.bram_rd_addr[IDX_W-1:0];
  assign wr_act  = (state_q != S_IDLE) && eng.write_en;
  assign wr_oob  = eng.bram_wr_addr >= ADDR_W'(DEPTH);
  assign wr_idx  = eng.bram_wr_addr[IDX_W-1:0];
  assign wr_ok   = wr_act && !wr_oob;
  assign pending = |pipe_vld_q;

  always_comb begin
    state_d      = state_q;
    done_d       = 1'b0;
    wr_count_d   = wr_count_q;
    addr_err_d   = addr_err_q;
    host_rdata_d = out_mem[host_raddr];
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_RUN;
          wr_count_d = '0;
          addr_err_d = 1'b0;
        end
      end
      S_RUN: begin
        if (eng.tile_done) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (!pending) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (rd_acc && rd_oob) addr_err_d = 1'b1;
    if (wr_act && wr_oob) addr_err_d = 1'b1;
    if (wr_ok && (wr_count_q != CNT_W'(DEPTH))) wr_count_d = wr_count_q + 1'b1;
    ready_d = (state_d == S_RUN);
  end

  always_comb begin
    pipe_vld_d = '0;
    pipe_pix_d = pipe_pix_q;
    pipe_wt_d  = pipe_wt_q;
    pipe_vld_d[0] = rd_acc;
    if (rd_acc) begin
      pipe_pix_d[0] = rd_oob ? '0 : pix_mem[rd_idx];
      pipe_wt_d[0]  = rd_oob ? '0 : wt_mem[rd_idx];
    end
    for (int k = 1; k < RD_LAT; k++) begin
      pipe_vld_d[k] = pipe_vld_q[k-1];
      if (pipe_vld_q[k-1]) begin
        pipe_pix_d[k] = pipe_pix_q[k-1];
        pipe_wt_d[k]  = pipe_wt_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ready_q      <= 1'b0;
      done_q       <= 1'b0;
      addr_err_q   <= 1'b0;
      wr_count_q   <= '0;
      host_rdata_q <= '0;
      pipe_vld_q   <= '0;
      for (int k = 0; k < RD_LAT; k++) begin
        pipe_pix_q[k] <= '0;
        pipe_wt_q[k]  <= '0;
      end
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      done_q       <= done_d;
      addr_err_q   <= addr_err_d;
      wr_count_q   <= wr_count_d;
      host_rdata_q <= host_rdata_d;
      pipe_vld_q   <= pipe_vld_d;
      pipe_pix_q   <= pipe_pix_d;
      pipe_wt_q    <= pipe_wt_d;
    end
  end

  // Memory arrays keep their contents across reset.
  always_ff @(posedge clk) begin
    if (host_we && (state_q == S_IDLE)) begin
      if (host_sel) wt_mem[host_addr]  <= host_wdata;
      else          pix_mem[host_addr] <= host_wdata;
    end
    if (wr_ok) out_mem[wr_idx] <= eng.output_pixels;
  end

  assign busy             = (state_q != S_IDLE);
  assign done             = done_q;
  assign wr_count         = wr_count_q;
  assign addr_err         = addr_err_q;
  assign host_rdata       = host_rdata_q;
  assign dbg_state        = state_q;
  assign eng.ready        = ready_q;
  assign eng.valid        = pipe_vld_q[RD_LAT-1];
  assign eng.input_pixels = pipe_pix_q[RD_LAT-1];
  assign eng.weights      = pipe_wt_q[RD_LAT-1];

endmodule

// File: tb/tb_conv_mem_responder.sv
// Directed and randomized bench for conv_mem_responder, checked against a cycle-level
// reference model of the memories, run window and read latency.
module tb_conv_mem_responder;
  localparam int DW     = 128;
  localparam int AW     = 32;
  localparam int DEPTH  = 256;
  localparam int RD_LAT = 2;
  localparam int IW     = $clog2(DEPTH);
  localparam int EW     = 32 + 2 * DW;

  logic          clk;
  logic          rst_n;
  logic          host_we, host_sel;
  logic [IW-1:0] host_addr, host_raddr;
  logic [DW-1:0] host_wdata, host_rdata;
  logic          start, busy, done, addr_err;
  logic [IW:0]   wr_count;
  logic [1:0]    dbg_state;

  conv_mem_responder_if #(.DATA_W(DW), .ADDR_W(AW)) eng ();

  conv_mem_responder #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .host_we(host_we), .host_sel(host_sel), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_raddr(host_raddr), .host_rdata(host_rdata),
    .start(start), .busy(busy), .done(done), .wr_count(wr_count), .addr_err(addr_err),
    .dbg_state(dbg_state),
    .eng(eng)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef enum {M_IDLE, M_RUN, M_DRAIN} mstate_t;
  mstate_t       m_state;
  logic [DW-1:0] pix_m [DEPTH];
  logic [DW-1:0] wt_m  [DEPTH];
  logic [DW-1:0] out_m [DEPTH];
  bit            out_known [DEPTH];
  logic [EW-1:0] exp_q[$];
  int            cyc, last_due, m_cnt;
  bit            m_err, m_done, hr_known;
  logic [DW-1:0] hr_exp, last_pix, last_wt;
  int            n_checks, n_pass;

  localparam logic [DW-1:0] PAT_A5 = {16{8'hA5}};
  localparam logic [DW-1:0] PAT_5A = {16{8'h5A}};

  function automatic logic [DW-1:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] expv);
    n_checks++;
    assert (got === expv) n_pass++;
    else $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, expv, cyc);
  endtask

  task automatic model_reset();
    m_state  = M_IDLE;
    exp_q.delete();
    last_due = -100;
    m_cnt    = 0;
    m_err    = 0;
    m_done   = 0;
    last_pix = '0;
    last_wt  = '0;
    hr_exp   = '0;
    hr_known = 1;
  endtask

  // Compare every observable output with the model (called away from the rising edge).
  task automatic check_outputs();
    logic [EW-1:0] e;
    bit v_exp;
    v_exp = 0;
    if (exp_q.size() != 0) begin
      e = exp_q[0];
      v_exp = (int'(e[EW-1 -: 32]) == cyc);
    end
    check("valid", eng.valid, v_exp);
    if (v_exp) begin
      void'(exp_q.pop_front());
      last_pix = e[2*DW-1 -: DW];
      last_wt  = e[DW-1:0];
      check("pixels", eng.input_pixels, last_pix);
      check("weights", eng.weights, last_wt);
    end else begin
      check("pixels_hold", eng.input_pixels, last_pix);
      check("weights_hold", eng.weights, last_wt);
    end
    check("ready", eng.ready, m_state == M_RUN);
    check("busy", busy, m_state != M_IDLE);
    check("done", done, m_done);
    check("wr_count", wr_count, m_cnt);
    check("addr_err", addr_err, m_err);
    check("dbg_known", (^dbg_state) !== 1'bx, 1'b1);
    if (hr_known) check("host_rdata", host_rdata, hr_exp);
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic tick();
    logic [DW-1:0] p, w;
    @(posedge clk);
    cyc++;
    m_done = 0;
    if (!rst_n) begin
      model_reset();
    end else begin
      hr_exp   = out_m[host_raddr];
      hr_known = out_known[host_raddr];
      if (m_state == M_RUN && eng.read_en) begin
        if (eng.bram_rd_addr >= DEPTH) begin
          p = '0; w = '0; m_err = 1;
        end else begin
          p = pix_m[eng.bram_rd_addr[IW-1:0]];
          w = wt_m[eng.bram_rd_addr[IW-1:0]];
        end
        last_due = cyc + RD_LAT - 1;
        exp_q.push_back({32'(last_due), p, w});
      end
      if (m_state != M_IDLE && eng.write_en) begin
        if (eng.bram_wr_addr >= DEPTH) m_err = 1;
        else begin
          out_m[eng.bram_wr_addr[IW-1:0]]     = eng.output_pixels;
          out_known[eng.bram_wr_addr[IW-1:0]] = 1;
          if (m_cnt < DEPTH) m_cnt++;
        end
      end
      if (m_state == M_IDLE && host_we) begin
        if (host_sel) wt_m[host_addr] = host_wdata;
        else          pix_m[host_addr] = host_wdata;
      end
      case (m_state)
        M_IDLE:  if (start) begin m_state = M_RUN; m_cnt = 0; m_err = 0; end
        M_RUN:   if (eng.tile_done) m_state = M_DRAIN;
        M_DRAIN: if (last_due < cyc - 1) begin m_state = M_IDLE; m_done = 1; end
        default: m_state = M_IDLE;
      endcase
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic clear_engine();
    eng.read_en = 0; eng.write_en = 0; eng.tile_done = 0;
  endtask

  task automatic begin_run();
    start = 1; tick(); start = 0;
  endtask

  task automatic finish_run();
    clear_engine();
    eng.tile_done = 1; tick(); eng.tile_done = 0;
    repeat (RD_LAT + 3) tick();
  endtask

  // ---------------- stimulus ----------------
  int done_cnt;

  initial begin
    rst_n = 0; start = 0; host_we = 0; host_sel = 0; host_addr = '0; host_wdata = '0;
    host_raddr = '0; eng.bram_rd_addr = '0; eng.bram_wr_addr = '0; eng.output_pixels = '0;
    clear_engine();
    cyc = 0; n_checks = 0; n_pass = 0;
    for (int i = 0; i < DEPTH; i++) out_known[i] = 0;
    model_reset();
    tick(); tick();
    rst_n = 1;
    tick();

    // Preload every pixel/weight word; address 3 gets the recognisable patterns.
    host_we = 1;
    for (int i = 0; i < DEPTH; i++) begin
      host_addr = IW'(i);
      host_sel = 0; host_wdata = (i == 3) ? PAT_A5 : rnd_word(); tick();
      host_sel = 1; host_wdata = (i == 3) ? PAT_5A : rnd_word(); tick();
    end
    host_we = 0;

    // Single read at address 3: data shows in the second cycle after the sampling edge.
    begin_run();
    eng.read_en = 1; eng.bram_rd_addr = 3; tick(); eng.read_en = 0;
    check("t032_valid_early", eng.valid, 1'b0);
    tick();
    check("t032_valid", eng.valid, 1'b1);
    check("t032_pix", eng.input_pixels, PAT_A5);
    check("t032_wt", eng.weights, PAT_5A);
    finish_run();

    // Back-to-back reads at 0..7.
    begin_run();
    for (int i = 0; i < 8; i++) begin
      eng.read_en = 1; eng.bram_rd_addr = AW'(i); tick();
    end
    clear_engine();
    repeat (2) tick();
    finish_run();

    // Writes 1..4 to 0..3, then readback of address 2.
    begin_run();
    for (int i = 0; i < 4; i++) begin
      eng.write_en = 1; eng.bram_wr_addr = AW'(i); eng.output_pixels = DW'(i + 1); tick();
    end
    done_cnt = 0;
    clear_engine();
    eng.tile_done = 1; tick(); eng.tile_done = 0;
    for (int i = 0; i < RD_LAT + 3; i++) begin tick(); done_cnt += int'(done); end
    check("t034_done_once", done_cnt, 1);
    check("t034_cnt", wr_count, 4);
    host_raddr = 2; tick();
    check("t034_hr", host_rdata, 3);

    // Out-of-range read and write in the same cycle.
    begin_run();
    eng.read_en = 1; eng.bram_rd_addr = 300;
    eng.write_en = 1; eng.bram_wr_addr = 256; eng.output_pixels = rnd_word();
    tick(); clear_engine();
    check("t035_err", addr_err, 1'b1);
    tick();
    check("t035_valid", eng.valid, 1'b1);
    check("t035_pix_zero", eng.input_pixels, '0);
    check("t035_cnt", wr_count, 0);
    finish_run();

    // tile_done together with a read: the read completes during DRAIN.
    begin_run();
    eng.read_en = 1; eng.bram_rd_addr = 5; eng.tile_done = 1; tick(); clear_engine();
    check("t036_ready_low", eng.ready, 1'b0);
    tick();
    check("t036_valid", eng.valid, 1'b1);
    done_cnt = 0;
    for (int i = 0; i < 5; i++) begin tick(); done_cnt += int'(done); end
    check("t036_done_once", done_cnt, 1);

    // Saturation: more writes than DEPTH; also fills the whole output memory.
    begin_run();
    for (int i = 0; i < DEPTH + 4; i++) begin
      eng.write_en = 1; eng.bram_wr_addr = AW'(i % DEPTH); eng.output_pixels = rnd_word();
      host_raddr = IW'($urandom_range(0, DEPTH - 1));
      tick();
    end
    check("sat_cnt", wr_count, DEPTH);
    finish_run();

    // Randomized run: reads, writes, stray host writes/start, then a random drain phase.
    for (int r = 0; r < 3; r++) begin
      begin_run();
      for (int i = 0; i < 60; i++) begin
        eng.read_en      = 1'($urandom_range(0, 1));
        eng.bram_rd_addr = ($urandom_range(0, 15) == 0) ? AW'(256 + $urandom_range(0, 1000))
                                                        : AW'($urandom_range(0, DEPTH - 1));
        eng.write_en     = 1'($urandom_range(0, 1));
        eng.bram_wr_addr = ($urandom_range(0, 15) == 0) ? AW'(256 + $urandom_range(0, 1000))
                                                        : AW'($urandom_range(0, DEPTH - 1));
        eng.output_pixels = rnd_word();
        host_we    = 1'($urandom_range(0, 1));
        host_sel   = 1'($urandom_range(0, 1));
        host_addr  = IW'($urandom_range(0, DEPTH - 1));
        host_wdata = rnd_word();
        host_raddr = IW'($urandom_range(0, DEPTH - 1));
        start      = ($urandom_range(0, 7) == 0);
        tick();
      end
      start = 0; host_we = 0;
      eng.tile_done = 1; tick();
      for (int i = 0; i < 6; i++) begin
        eng.tile_done    = 1'($urandom_range(0, 1));
        eng.read_en      = 1'($urandom_range(0, 1));
        eng.bram_rd_addr = AW'($urandom_range(0, DEPTH - 1));
        eng.write_en     = 1'($urandom_range(0, 1));
        eng.bram_wr_addr = AW'($urandom_range(0, DEPTH - 1));
        eng.output_pixels = rnd_word();
        host_raddr = IW'($urandom_range(0, DEPTH - 1));
        tick();
      end
      clear_engine();
      // Host writes while idle land in the memories (address 3 left untouched).
      for (int i = 0; i < 4; i++) begin
        host_we = 1; host_sel = 1'($urandom_range(0, 1));
        host_addr = IW'($urandom_range(4, DEPTH - 1)); host_wdata = rnd_word();
        tick();
      end
      host_we = 0;
    end
    host_raddr = 2; tick();

    // Reset in the middle of a run with reads in flight.
    begin_run();
    eng.read_en = 1; eng.bram_rd_addr = 3; tick();
    eng.bram_rd_addr = 4; tick();
    clear_engine();
    rst_n = 0;
    #1;
    model_reset();
    check("t037_ready_now", eng.ready, 1'b0);
    check("t037_valid_now", eng.valid, 1'b0);
    check_outputs();
    tick();
    rst_n = 1;
    repeat (4) tick();
    begin_run();
    eng.read_en = 1; eng.bram_rd_addr = 3; tick(); clear_engine();
    tick();
    check("t037_pix_kept", eng.input_pixels, PAT_A5);
    check("t037_wt_kept", eng.weights, PAT_5A);
    finish_run();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
